crossroad_pulse_gen: RTL and testbench

Timing sequencer that drives the control inputs of `car_crossroad`. It runs a four-phase tick-based schedule: A green, A yellow, B green, B yellow. It emits the single-cycle `crossroad_status_changed_in` pulse at each phase end, and the `signal_car_to_cross_if_green_in` pulse at a fixed crossing interval during green phases. It replaces the hand-driven pulses used in simulation and sits between the board tick source and `car_crossroad`.

---
 rtl/crossroad_pulse_gen.sv | 97 +++++++++
 tb/tb_crossroad_pulse_gen.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossroad_pulse_gen.sv
// Four-phase tick sequencer for car_crossroad: emits the status-change pulse at
// every phase end and the car-cross pulse at a fixed cadence inside green phases.
module crossroad_pulse_gen #(
    parameter int GREEN_TICKS  = 30,
    parameter int YELLOW_TICKS = 5,
    parameter int CROSS_TICKS  = 3,
    parameter int TICK_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       run,
    input  logic       skip_in,
    output logic       status_change_out,
    output logic       car_cross_out,
    output logic [1:0] phase_out
);

    typedef enum logic [1:0] {
        A_GREEN  = 2'd0,
        A_YELLOW = 2'd1,
        B_GREEN  = 2'd2,
        B_YELLOW = 2'd3
    } phase_t;

    localparam logic [TICK_W-1:0] GREEN_LAST  = TICK_W'(GREEN_TICKS - 1);
    localparam logic [TICK_W-1:0] YELLOW_LAST = TICK_W'(YELLOW_TICKS - 1);
    localparam logic [TICK_W-1:0] CROSS_LAST  = TICK_W'(CROSS_TICKS - 1);
    localparam logic [TICK_W-1:0] CNT_ONE     = TICK_W'(1);

    phase_t            phase_q, phase_d;
    logic [TICK_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [TICK_W-1:0] cross_cnt_q, cross_cnt_d;
    logic              status_d, car_d;

    logic              is_green;
    logic              accepted;
    logic [TICK_W-1:0] dur_last;
    logic              phase_end;

    // Green phases have an even encoding, so bit 0 alone selects the duration.
    assign is_green  = ~phase_q[0];
    assign accepted  = tick & run;
    assign dur_last  = is_green ? GREEN_LAST : YELLOW_LAST;
    assign phase_end = skip_in | (accepted & (phase_cnt_q == dur_last));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q           <= A_GREEN;
            phase_cnt_q       <= '0;
            cross_cnt_q       <= '0;
            status_change_out <= 1'b0;
            car_cross_out     <= 1'b0;
        end else begin
            phase_q           <= phase_d;
            phase_cnt_q       <= phase_cnt_d;
            cross_cnt_q       <= cross_cnt_d;
            status_change_out <= status_d;
            car_cross_out     <= car_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the if/else tree can leave a signal unassigned and infer a latch.
    always_comb begin
        phase_d     = phase_q;
        phase_cnt_d = phase_cnt_q;
        cross_cnt_d = cross_cnt_q;
        status_d    = 1'b0;
        car_d       = 1'b0;

        if (phase_end) begin
            // A phase end suppresses any car pulse due on the same tick.
            phase_d     = phase_t'(phase_q + 2'd1);
            phase_cnt_d = '0;
            cross_cnt_d = '0;
            status_d    = 1'b1;
        end else if (accepted) begin
            phase_cnt_d = phase_cnt_q + CNT_ONE;
            if (is_green) begin
                if (cross_cnt_q == CROSS_LAST) begin
                    cross_cnt_d = '0;
                    car_d       = 1'b1;
                end else begin
                    cross_cnt_d = cross_cnt_q + CNT_ONE;
                end
            end else begin
                cross_cnt_d = '0;
            end
        end
    end

    assign phase_out = phase_q;

endmodule

// File: tb/tb_crossroad_pulse_gen.sv
// Self-checking bench for crossroad_pulse_gen: a cycle model feeds a scoreboard
// queue, and scenario tasks add directed checks on the timing of each pulse.
module tb_crossroad_pulse_gen;

    localparam int GREEN  = 4;
    localparam int YELLOW = 2;
    localparam int CROSS  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b1;
    logic       run = 1'b1;
    logic       skip_in = 1'b0;
    logic       status_change_out;
    logic       car_cross_out;
    logic [1:0] phase_out;

    crossroad_pulse_gen #(
        .GREEN_TICKS (GREEN),
        .YELLOW_TICKS(YELLOW),
        .CROSS_TICKS (CROSS),
        .TICK_W      (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tick             (tick),
        .run              (run),
        .skip_in          (skip_in),
        .status_change_out(status_change_out),
        .car_cross_out    (car_cross_out),
        .phase_out        (phase_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ph;
        logic       st;
        logic       car;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int m_phase = 0;
    int m_cnt   = 0;
    int m_cross = 0;

    // Reference model advances on the inputs present before the edge; the DUT
    // result is scored 1 time unit after the edge.
    task automatic step();
        exp_t e;
        bit   green, acc, pe;
        int   dur;
        green = (m_phase == 0) || (m_phase == 2);
        dur   = green ? GREEN : YELLOW;
        acc   = tick && run;
        pe    = skip_in || (acc && (m_cnt == dur - 1));
        e.st  = pe;
        e.car = 1'b0;
        if (pe) begin
            m_phase = (m_phase + 1) % 4;
            m_cnt   = 0;
            m_cross = 0;
        end else if (acc) begin
            m_cnt++;
            if (green) begin
                if (m_cross == CROSS - 1) begin
                    m_cross = 0;
                    e.car   = 1'b1;
                end else begin
                    m_cross++;
                end
            end else begin
                m_cross = 0;
            end
        end
        e.ph = 2'(m_phase);
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: scoreboard had no entry at t=%0t", $time);
        end else begin
            e = sb.pop_front();
            if ({phase_out, status_change_out, car_cross_out} !== {e.ph, e.st, e.car}) begin
                n_bad++;
                $display("FAIL sb_outputs t=%0t: got phase=%0d st=%b car=%b, want phase=%0d st=%b car=%b",
                         $time, phase_out, status_change_out, car_cross_out, e.ph, e.st, e.car);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        skip_in = 1'b0;
        tick = 1'b1;
        run = 1'b1;
        m_phase = 0;
        m_cnt = 0;
        m_cross = 0;
        sb.delete();
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0;
        #3;
        n_cmp++;
        if ({phase_out, status_change_out, car_cross_out} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_values: got phase=%0d st=%b car=%b, want 0 0 0",
                     phase_out, status_change_out, car_cross_out);
        end
        @(posedge clk);
        #1;
        do_reset();
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (status_change_out === 1'b1) begin
                n = c;
                break;
            end
        end
        n_cmp++;
        if (n != 4 || phase_out !== 2'd1) begin
            n_bad++;
            $display("FAIL first_phase_end: got cycle=%0d phase=%0d, want cycle=4 phase=1", n, phase_out);
        end
    endtask

    task automatic test_full_cycle();
        logic [11:0] st_mask;
        logic [7:0]  ph_seq;
        int          k;
        do_reset();
        st_mask = '0;
        ph_seq  = '0;
        k = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            st_mask[c-1] = status_change_out;
            if (status_change_out === 1'b1 && k < 4) begin
                ph_seq[k*2 +: 2] = phase_out;
                k++;
            end
        end
        n_cmp++;
        if (st_mask !== 12'hA28) begin
            n_bad++;
            $display("FAIL full_cycle_pulses: got mask=%h, want mask=a28", st_mask);
        end
        n_cmp++;
        if (ph_seq !== 8'b00_11_10_01) begin
            n_bad++;
            $display("FAIL full_cycle_phases: got seq=%b, want seq=00111001", ph_seq);
        end
    endtask

    task automatic test_crossing();
        logic [5:0] car_mask;
        logic       both;
        do_reset();
        car_mask = '0;
        both = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            car_mask[c-1] = car_cross_out;
            if (car_cross_out === 1'b1 && status_change_out === 1'b1) both = 1'b1;
        end
        n_cmp++;
        if (car_mask !== 6'b000010) begin
            n_bad++;
            $display("FAIL cross_cadence: got mask=%b, want mask=000010", car_mask);
        end
        n_cmp++;
        if (both !== 1'b0) begin
            n_bad++;
            $display("FAIL cross_exclusive: got both=%b, want both=0", both);
        end
    endtask

    task automatic test_skip();
        do_reset();
        step();
        skip_in = 1'b1;
        step();
        skip_in = 1'b0;
        n_cmp++;
        if (status_change_out !== 1'b1 || phase_out !== 2'd1) begin
            n_bad++;
            $display("FAIL skip_advance: got st=%b phase=%0d, want st=1 phase=1", status_change_out, phase_out);
        end
        step();
        step();
        n_cmp++;
        if (status_change_out !== 1'b1 || phase_out !== 2'd2) begin
            n_bad++;
            $display("FAIL skip_yellow_len: got st=%b phase=%0d, want st=1 phase=2", status_change_out, phase_out);
        end
        repeat (3) step();
        skip_in = 1'b1;
        step();
        skip_in = 1'b0;
        step();
        n_cmp++;
        if (status_change_out !== 1'b0 || phase_out !== 2'd3) begin
            n_bad++;
            $display("FAIL skip_coincide: got st=%b phase=%0d, want st=0 phase=3", status_change_out, phase_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] st_pair;
        do_reset();
        run = 1'b0;
        skip_in = 1'b1;
        step();
        st_pair[0] = status_change_out;
        step();
        st_pair[1] = status_change_out;
        skip_in = 1'b0;
        n_cmp++;
        if (st_pair !== 2'b11 || phase_out !== 2'd2) begin
            n_bad++;
            $display("FAIL back_to_back_skip: got pulses=%b phase=%0d, want pulses=11 phase=2", st_pair, phase_out);
        end
        run = 1'b1;
    endtask

    task automatic test_pause();
        logic quiet;
        int   n;
        do_reset();
        step();
        run = 1'b0;
        quiet = 1'b1;
        repeat (10) begin
            step();
            if (status_change_out !== 1'b0 || car_cross_out !== 1'b0 || phase_out !== 2'd0) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_bad++;
            $display("FAIL pause_frozen: got quiet=%b, want quiet=1", quiet);
        end
        run = 1'b1;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (status_change_out === 1'b1) begin
                n = c;
                break;
            end
        end
        n_cmp++;
        if (n != 3) begin
            n_bad++;
            $display("FAIL pause_resume: got ticks=%0d, want ticks=3", n);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (4) step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({phase_out, status_change_out, car_cross_out} !== 4'b0000) begin
            n_bad++;
            $display("FAIL async_reset_cut: got phase=%0d st=%b car=%b, want 0 0 0",
                     phase_out, status_change_out, car_cross_out);
        end
        m_phase = 0;
        m_cnt = 0;
        m_cross = 0;
        sb.delete();
        rst = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick    = ($urandom_range(0, 3) != 0);
            run     = ($urandom_range(0, 7) != 0);
            skip_in = ($urandom_range(0, 15) == 0);
            step();
            n_cmp++;
            if (status_change_out === 1'b1 && car_cross_out === 1'b1) begin
                n_bad++;
                $display("FAIL random_exclusive t=%0t: got st=1 car=1, want at most one", $time);
            end
        end
        skip_in = 1'b0;
        tick = 1'b1;
        run = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_crossing();
        test_skip();
        test_back_to_back();
        test_pause();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
